// File: rtl/gpu_pkg.sv
// rtl/gpu_pkg.sv - shared types and constants for the GPU rectangle loader
package gpu_pkg;

    localparam int COORD_WIDTH = 16;
    localparam int COLOR_WIDTH = 16;
    localparam int RECT_COUNT  = 64;
    localparam int IDX_WIDTH   = $clog2(RECT_COUNT);
    localparam int START_DELAY = 2;
    localparam int WORD_COUNT  = 6;

    // Loader sequencing states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DELAY = 2'd1,
        ST_LOAD  = 2'd2,
        ST_DONE  = 2'd3
    } load_state_t;

    // Position of each word inside a 6-word rectangle packet
    localparam logic [2:0] W_HDR   = 3'd0;
    localparam logic [2:0] W_X     = 3'd1;
    localparam logic [2:0] W_Y     = 3'd2;
    localparam logic [2:0] W_W     = 3'd3;
    localparam logic [2:0] W_H     = 3'd4;
    localparam logic [2:0] W_COLOR = 3'd5;

    // Edge-form table entry, x1 in the MSBs
    typedef struct packed {
        logic [COORD_WIDTH-1:0] x1;
        logic [COORD_WIDTH-1:0] y1;
        logic [COORD_WIDTH-1:0] x2;
        logic [COORD_WIDTH-1:0] y2;
        logic [COLOR_WIDTH-1:0] color;
    } rect_entry_t;

endpackage

// File: rtl/rect_edge_calc.sv
// rtl/rect_edge_calc.sv - saturating origin+size to far-edge conversion
module rect_edge_calc
    import gpu_pkg::*;
#(
    parameter int CW = COORD_WIDTH
) (
    input  logic [CW-1:0] i_x1,
    input  logic [CW-1:0] i_y1,
    input  logic [CW-1:0] i_w,
    input  logic [CW-1:0] i_h,
    output logic [CW-1:0] o_x2,
    output logic [CW-1:0] o_y2
);

    logic [CW:0] w_sum_x;
    logic [CW:0] w_sum_y;

    // One extra bit catches the carry; an edge past the coordinate range clamps to all-ones
    always_comb begin
        w_sum_x = {1'b0, i_x1} + {1'b0, i_w};
        w_sum_y = {1'b0, i_y1} + {1'b0, i_h};
        o_x2    = w_sum_x[CW] ? {CW{1'b1}} : w_sum_x[CW-1:0];
        o_y2    = w_sum_y[CW] ? {CW{1'b1}} : w_sum_y[CW-1:0];
    end

endmodule

// File: rtl/gpu_rect_loader.sv
// rtl/gpu_rect_loader.sv - turns the rectangle DMA stream into GPU table writes
module gpu_rect_loader
    import gpu_pkg::*;
#(
    parameter int COORD_WIDTH = gpu_pkg::COORD_WIDTH,
    parameter int RECT_COUNT  = gpu_pkg::RECT_COUNT,
    parameter int IDX_WIDTH   = gpu_pkg::IDX_WIDTH,
    parameter int START_DELAY = gpu_pkg::START_DELAY
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        copy_start,
    input  logic [15:0]                 stream_din,
    output logic                        rect_we,
    output logic [IDX_WIDTH-1:0]        rect_waddr,
    output logic [4*COORD_WIDTH+15:0]   rect_wdata,
    output logic                        busy,
    output logic                        load_done,
    output logic                        hdr_err
);

    // Counter just wide enough to hold START_DELAY-1
    localparam int DLY_W = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;

    load_state_t                r_state;
    load_state_t                w_state_next;
    logic [DLY_W-1:0]           r_dly;
    logic [2:0]                 r_word;
    logic [IDX_WIDTH-1:0]       r_idx;
    logic [COORD_WIDTH-1:0]     r_x1;
    logic [COORD_WIDTH-1:0]     r_y1;
    logic [COORD_WIDTH-1:0]     r_w;
    logic [COORD_WIDTH-1:0]     r_h;
    logic                       r_we;
    logic [IDX_WIDTH-1:0]       r_waddr;
    logic [4*COORD_WIDTH+15:0]  r_wdata;
    logic                       r_load_done;
    logic                       r_hdr_err;
    logic [COORD_WIDTH-1:0]     w_x2;
    logic [COORD_WIDTH-1:0]     w_y2;
    logic                       w_last_word;
    logic                       w_last_rect;

    assign w_last_word = (r_word == W_COLOR);
    assign w_last_rect = (r_idx == IDX_WIDTH'(RECT_COUNT - 1));

    rect_edge_calc #(
        .CW (COORD_WIDTH)
    ) u_edge_calc (
        .i_x1 (r_x1),
        .i_y1 (r_y1),
        .i_w  (r_w),
        .i_h  (r_h),
        .o_x2 (w_x2),
        .o_y2 (w_y2)
    );

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; a start strobe is only honoured from IDLE
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (copy_start) begin
                    w_state_next = ST_DELAY;
                end
            end
            ST_DELAY: begin
                if (r_dly == '0) begin
                    w_state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (w_last_word && w_last_rect) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Counters, packet capture and registered table-write outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_dly       <= '0;
            r_word      <= '0;
            r_idx       <= '0;
            r_x1        <= '0;
            r_y1        <= '0;
            r_w         <= '0;
            r_h         <= '0;
            r_we        <= 1'b0;
            r_waddr     <= '0;
            r_wdata     <= '0;
            r_load_done <= 1'b0;
            r_hdr_err   <= 1'b0;
        end else begin
            r_we        <= 1'b0;
            r_load_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (copy_start) begin
                        r_dly     <= DLY_W'(START_DELAY - 1);
                        r_word    <= '0;
                        r_idx     <= '0;
                        r_hdr_err <= 1'b0;
                    end
                end
                ST_DELAY: begin
                    if (r_dly != '0) begin
                        r_dly <= r_dly - 1'b1;
                    end
                end
                ST_LOAD: begin
                    r_word <= w_last_word ? 3'd0 : r_word + 3'd1;
                    case (r_word)
                        W_HDR: begin
                            if (stream_din != 16'h0000) begin
                                r_hdr_err <= 1'b1;
                            end
                        end
                        W_X: r_x1 <= stream_din[COORD_WIDTH-1:0];
                        W_Y: r_y1 <= stream_din[COORD_WIDTH-1:0];
                        W_W: r_w  <= stream_din[COORD_WIDTH-1:0];
                        W_H: r_h  <= stream_din[COORD_WIDTH-1:0];
                        W_COLOR: begin
                            r_we        <= 1'b1;
                            r_waddr     <= r_idx;
                            r_wdata     <= {r_x1, r_y1, w_x2, w_y2, stream_din};
                            r_idx       <= r_idx + 1'b1;
                            r_load_done <= w_last_rect;
                        end
                        default: begin
                        end
                    endcase
                end
                default: begin
                end
            endcase
        end
    end

    assign rect_we    = r_we;
    assign rect_waddr = r_waddr;
    assign rect_wdata = r_wdata;
    assign load_done  = r_load_done;
    assign hdr_err    = r_hdr_err;
    assign busy       = (r_state != ST_IDLE);

endmodule
